// File: rtl/game_pkg.sv
// Shared definitions for the cat-and-mouse game: round state encoding,
// default move-rate constants and the step-timer firing rule.
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_COUNT = 3'd2,
        ST_PLAY  = 3'd3,
        ST_OVER  = 3'd4
    } state_e;

    localparam int DEF_BASE_PERIOD = 65;
    localparam int DEF_MAX_CHEESE  = 64;

    // A step is due once the counter has reached period-1; using >= lets a
    // period that shrank below the current count fire instead of wrapping.
    function automatic logic stepDue(input logic [7:0] count, input logic [7:0] period);
        return ({1'b0, count} + 9'd1) >= {1'b0, period};
    endfunction

endpackage

// File: rtl/game_scheduler_step_timer.sv
// Free-running step counter producing a one-cycle move strobe every
// `period` enabled cycles.
module step_timer
    import game_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       en,
    input  logic       clr,
    input  logic [7:0] period,
    output logic       step
);

    logic [7:0] count;

    // Step counter and registered strobe
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= 8'd0;
            step  <= 1'b0;
        end else if (clr) begin
            count <= 8'd0;
            step  <= 1'b0;
        end else if (en) begin
            if (stepDue(count, period)) begin
                count <= 8'd0;
                step  <= 1'b1;
            end else begin
                count <= count + 8'd1;
                step  <= 1'b0;
            end
        end else begin
            step <= 1'b0;
        end
    end

endmodule

// File: rtl/game_scheduler.sv
// Round sequencer (idle, clear, countdown, play, over) and cheese-dependent
// move-rate scheduler for the mouse and cat.
module game_scheduler
    import game_pkg::*;
#(
    parameter int BASE_PERIOD     = DEF_BASE_PERIOD,
    parameter int MAX_CHEESE      = DEF_MAX_CHEESE,
    parameter int COUNTDOWN_TICKS = 3,
    parameter int SEC_DIV         = 50_000_000
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              start,
    input  logic                              game_over_in,
    input  logic                              cheese_event,
    output logic                              game_clear,
    output logic                              play_en,
    output logic                              mouse_step,
    output logic                              cat_step,
    // Sized to hold MAX_CHEESE itself, not just MAX_CHEESE-1
    output logic [$clog2(MAX_CHEESE+1)-1:0]   cheese_count,
    output logic [1:0]                        countdown,
    output logic [2:0]                        state
);

    localparam int CW    = $clog2(MAX_CHEESE + 1);
    localparam int DIV_W = (SEC_DIV > 1) ? $clog2(SEC_DIV) : 1;

    state_e           stateR;
    logic [DIV_W-1:0] divCount;
    logic [7:0]       mousePeriod;
    logic [7:0]       catPeriod;
    logic             stepEn;
    logic             stepClr;

    // Periods follow the registered cheese count, so a new count applies next cycle
    always_comb begin
        mousePeriod = 8'(BASE_PERIOD) + 8'(cheese_count);
        catPeriod   = 8'(BASE_PERIOD) - 8'(cheese_count);
        // A collision in this cycle suppresses any strobe from this edge on
        stepEn      = (stateR == ST_PLAY) && !game_over_in;
        stepClr     = (stateR == ST_CLEAR);
    end

    // Round state machine, countdown divider and cheese counter
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stateR       <= ST_IDLE;
            divCount     <= '0;
            game_clear   <= 1'b0;
            play_en      <= 1'b0;
            cheese_count <= '0;
            countdown    <= 2'd0;
        end else begin
            game_clear <= 1'b0;
            case (stateR)
                ST_IDLE, ST_OVER: begin
                    if (start) begin
                        stateR       <= ST_CLEAR;
                        game_clear   <= 1'b1;
                        cheese_count <= '0;
                        divCount     <= '0;
                    end else begin
                        stateR <= stateR;
                    end
                end
                ST_CLEAR: begin
                    stateR       <= ST_COUNT;
                    cheese_count <= '0;
                    divCount     <= '0;
                    countdown    <= 2'(COUNTDOWN_TICKS);
                end
                ST_COUNT: begin
                    if (divCount == DIV_W'(SEC_DIV - 1)) begin
                        divCount <= '0;
                        if (countdown == 2'd1) begin
                            stateR    <= ST_PLAY;
                            play_en   <= 1'b1;
                            countdown <= 2'd0;
                        end else begin
                            countdown <= countdown - 2'd1;
                        end
                    end else begin
                        divCount <= divCount + DIV_W'(1);
                    end
                end
                ST_PLAY: begin
                    if (game_over_in) begin
                        stateR  <= ST_OVER;
                        play_en <= 1'b0;
                    end else if (cheese_event && (cheese_count < CW'(MAX_CHEESE))) begin
                        cheese_count <= cheese_count + CW'(1);
                    end else begin
                        cheese_count <= cheese_count;
                    end
                end
                default: begin
                    stateR  <= ST_IDLE;
                    play_en <= 1'b0;
                end
            endcase
        end
    end

    assign state = stateR;

    step_timer u_mouseTimer (
        .clock  (clock),
        .reset  (reset),
        .en     (stepEn),
        .clr    (stepClr),
        .period (mousePeriod),
        .step   (mouse_step)
    );

    step_timer u_catTimer (
        .clock  (clock),
        .reset  (reset),
        .en     (stepEn),
        .clr    (stepClr),
        .period (catPeriod),
        .step   (cat_step)
    );

endmodule

// File: tb/tb_game_scheduler.sv
// Directed bench for game_scheduler: strobe and clear-pulse schedules are
// predicted per edge into queues and compared on every falling edge.
module tb_game_scheduler;

    logic       clock;
    logic       reset;
    logic       start;
    logic       game_over_in;
    logic       cheese_event;
    logic       game_clear;
    logic       play_en;
    logic       mouse_step;
    logic       cat_step;
    logic [6:0] cheese_count;
    logic [1:0] countdown;
    logic [2:0] state;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit monOn    = 1'b0;
    int mq[$];
    int cq[$];
    int gq[$];

    game_scheduler #(
        .BASE_PERIOD     (65),
        .MAX_CHEESE      (64),
        .COUNTDOWN_TICKS (3),
        .SEC_DIV         (4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .game_over_in (game_over_in),
        .cheese_event (cheese_event),
        .game_clear   (game_clear),
        .play_en      (play_en),
        .mouse_step   (mouse_step),
        .cat_step     (cat_step),
        .cheese_count (cheese_count),
        .countdown    (countdown),
        .state        (state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Rising-edge index; after edge k the DUT outputs are observed with cyc == k
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic waitEdge(input int e);
        while (cyc < e) @(negedge clock);
    endtask

    function automatic logic [15:0] packOut();
        return {game_clear, play_en, mouse_step, cat_step, cheese_count, countdown, state};
    endfunction

    // Scoreboard: pop predicted strobe/clear edges and compare every cycle
    initial begin
        bit expM, expC, expG;
        forever begin
            @(negedge clock);
            if (monOn) begin
                expM = (mq.size() > 0) && (mq[0] == cyc);
                expC = (cq.size() > 0) && (cq[0] == cyc);
                expG = (gq.size() > 0) && (gq[0] == cyc);
                if (expM) void'(mq.pop_front());
                if (expC) void'(cq.pop_front());
                if (expG) void'(gq.pop_front());
                check("mouse_step", {31'd0, mouse_step}, {31'd0, expM});
                check("cat_step",   {31'd0, cat_step},   {31'd0, expC});
                check("game_clear", {31'd0, game_clear}, {31'd0, expG});
            end
        end
    end

    initial begin
        int n, p, q, r, t, n2, p2, n3, p3;
        reset = 1'b0; start = 1'b0; game_over_in = 1'b0; cheese_event = 1'b0;
        #1;
        check("resetOutputs", {16'd0, packOut()}, 32'd0);
        waitEdge(2);
        reset = 1'b1;
        monOn = 1'b1;

        // Reset then start: start sampled at edge 10
        n = 10;
        p = n + 13;
        waitEdge(n - 1);
        start = 1'b1;
        gq.push_back(n);
        for (int k = 1; k <= 10; k++) begin
            mq.push_back(p + 65 * k);
            cq.push_back(p + 65 * k);
        end
        waitEdge(n);
        start = 1'b0;
        check("clearState", {29'd0, state}, 32'd1);
        waitEdge(n + 1);
        check("countState", {29'd0, state}, 32'd2);
        check("countdown3", {30'd0, countdown}, 32'd3);
        start = 1'b1;
        game_over_in = 1'b1;
        waitEdge(n + 3);
        start = 1'b0;
        game_over_in = 1'b0;
        check("countIgnoresInputs", {29'd0, state}, 32'd2);
        waitEdge(n + 4);
        check("countdown3late", {30'd0, countdown}, 32'd3);
        waitEdge(n + 5);
        check("countdown2", {30'd0, countdown}, 32'd2);
        waitEdge(n + 9);
        check("countdown1", {30'd0, countdown}, 32'd1);
        waitEdge(p - 1);
        check("playEnBeforeEntry", {31'd0, play_en}, 32'd0);
        check("stillCount", {29'd0, state}, 32'd2);
        waitEdge(p);
        check("playEnEntry", {31'd0, play_en}, 32'd1);
        check("playState", {29'd0, state}, 32'd3);
        check("countdown0", {30'd0, countdown}, 32'd0);

        // Base rate: 650 cycles of play, both strobes every 65 cycles
        q = p + 650;
        waitEdge(q);
        check("baseCheese", {25'd0, cheese_count}, 32'd0);

        // Five cheese right after both counters restart: periods 70 / 60
        for (int k = 1; k <= 6; k++) mq.push_back(q + 70 * k);
        for (int k = 1; k <= 7; k++) cq.push_back(q + 60 * k);
        cheese_event = 1'b1;
        waitEdge(q + 5);
        cheese_event = 1'b0;
        check("cheese5", {25'd0, cheese_count}, 32'd5);

        // Shrink: cheese sampled when the cat counter is at its old period-2
        r = q + 420;
        t = r + 400;
        waitEdge(r);
        check("cheese5hold", {25'd0, cheese_count}, 32'd5);
        cq.push_back(r + 60);
        cq.push_back(r + 90);
        cq.push_back(r + 105);
        cq.push_back(r + 113);
        cq.push_back(r + 117);
        for (int e = r + 119; e <= t; e++) cq.push_back(e);
        mq.push_back(r + 129);
        mq.push_back(r + 258);
        mq.push_back(r + 387);
        waitEdge(r + 58);
        cheese_event = 1'b1;
        waitEdge(r + 59);
        cheese_event = 1'b0;
        check("cheese6", {25'd0, cheese_count}, 32'd6);
        waitEdge(r + 60);
        check("shrinkCatStep", {31'd0, cat_step}, 32'd1);

        // Saturation: 70 consecutive cheese
        cheese_event = 1'b1;
        waitEdge(r + 130);
        cheese_event = 1'b0;
        check("cheeseSat", {25'd0, cheese_count}, 32'd64);
        waitEdge(t);
        check("cheeseSatHold", {25'd0, cheese_count}, 32'd64);
        check("catEveryCycle", {31'd0, cat_step}, 32'd1);

        // Game over together with cheese while the cat fires every cycle
        game_over_in = 1'b1;
        cheese_event = 1'b1;
        waitEdge(t + 1);
        game_over_in = 1'b0;
        cheese_event = 1'b0;
        check("overState", {29'd0, state}, 32'd4);
        check("overPlayEn", {31'd0, play_en}, 32'd0);
        check("overCatStep", {31'd0, cat_step}, 32'd0);
        check("overCheese", {25'd0, cheese_count}, 32'd64);
        waitEdge(t + 10);
        check("overFrozen", {25'd0, cheese_count}, 32'd64);

        // Restart from OVER
        n2 = t + 11;
        p2 = n2 + 13;
        start = 1'b1;
        gq.push_back(n2);
        waitEdge(n2);
        start = 1'b0;
        check("restartClear", {29'd0, state}, 32'd1);
        check("restartCheese", {25'd0, cheese_count}, 32'd0);
        waitEdge(p2);
        check("round2Play", {29'd0, state}, 32'd3);
        cheese_event = 1'b1;
        waitEdge(p2 + 2);
        cheese_event = 1'b0;
        check("round2Cheese", {25'd0, cheese_count}, 32'd2);
        waitEdge(p2 + 9);
        game_over_in = 1'b1;
        cheese_event = 1'b1;
        waitEdge(p2 + 10);
        game_over_in = 1'b0;
        cheese_event = 1'b0;
        check("round2Over", {29'd0, state}, 32'd4);
        check("round2CheeseDropped", {25'd0, cheese_count}, 32'd2);

        // Third round, then asynchronous reset between clock edges
        n3 = p2 + 20;
        p3 = n3 + 13;
        waitEdge(n3 - 1);
        start = 1'b1;
        gq.push_back(n3);
        waitEdge(n3);
        start = 1'b0;
        waitEdge(p3);
        check("round3Play", {29'd0, state}, 32'd3);
        waitEdge(p3 + 30);
        #2;
        reset = 1'b0;
        #1;
        check("asyncResetOutputs", {16'd0, packOut()}, 32'd0);
        waitEdge(cyc + 3);
        reset = 1'b1;
        waitEdge(cyc + 3);
        check("idleAfterReset", {29'd0, state}, 32'd0);
        check("queuesDrained", mq.size() + cq.size() + gq.size(), 32'd0);

        monOn = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
